// File: rtl/sensor_event_hub.sv
// sensor_event_hub: concentrates NUM_CH raw sensor level flags into a serial
// event stream. Each flag is synchronised (2 flops), debounced (HOLD_CYCLES),
// and every debounced rising edge becomes a pending event. Pending events are
// drained lowest-index first into a FIFO that is read over valid/ready.
// Lost (coalesced) events raise a sticky overflow flag.
//
// Optional feature: define SENSOR_EVENT_HUB_TIMESTAMP_EN to add parameter
// TS_W, a free-running timestamp counter and an ev_ts output that carries the
// time at which the head event became pending.
module sensor_event_hub #(
    parameter int NUM_CH      = 9,
    parameter int HOLD_CYCLES = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int ID_W        = $clog2(NUM_CH)
`ifdef SENSOR_EVENT_HUB_TIMESTAMP_EN
    ,
    parameter int TS_W        = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ev_in,
    input  logic                          clr_ovf,
    input  logic                          ev_ready,
    output logic                          ev_valid,
    output logic [ID_W-1:0]               ev_id,
    output logic [NUM_CH-1:0]             ev_state,
    output logic                          overflow,
`ifdef SENSOR_EVENT_HUB_TIMESTAMP_EN
    output logic [TS_W-1:0]               ev_ts,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    // ------------------------------------------------------------------
    // Two-flop synchroniser on the raw asynchronous flags
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;

    // Next value of the synchroniser chain
    always_comb begin
        sync1_d = ev_in;
        sync2_d = sync1_q;
    end

    // Synchroniser registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce: a new level must persist HOLD_CYCLES cycles
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] state_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             st_q, st_d;

            // Count consecutive disagreeing samples; accept on the last one
            always_comb begin
                cnt_d = cnt_q;
                st_d  = st_q;
                if (sync2_q[gi] == st_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    st_d  = sync2_q[gi];
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Debounce counter and accepted level
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                    st_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    st_q  <= st_d;
                end
            end

            assign state_vec[gi] = st_q;
        end
    endgenerate

    assign ev_state = state_vec;

    // ------------------------------------------------------------------
    // Edge detect, pending bits, arbitration and overflow
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] prev_q, prev_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic              overflow_q, overflow_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] lowest;
    logic [NUM_CH-1:0] drain_oh;
    logic [NUM_CH-1:0] coalesce;
    logic [ID_W-1:0]   drain_id;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic [CW-1:0]     count_q, count_d;
    logic              valid_q, valid_d;

    // Select the lowest pending channel and update pending/overflow state
    always_comb begin
        prev_d    = state_vec;
        rise      = state_vec & ~prev_q;
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        lowest    = pend_q & (~pend_q + NUM_CH'(1));
        drain_id  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                drain_id = ID_W'(i);
            end
        end
        // A full FIFO blocks the write even if the head is popped this cycle.
        push       = (|pend_q) && !fifo_full;
        drain_oh   = push ? lowest : '0;
        // A rise on a channel being drained this cycle is a fresh event.
        coalesce   = rise & pend_q & ~drain_oh;
        pend_d     = (pend_q & ~drain_oh) | rise;
        overflow_d = (|coalesce) | (overflow_q & ~clr_ovf);
    end

    // Edge-detect history, pending bits and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  id_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointer, occupancy and valid bookkeeping
    always_comb begin
        pop      = valid_q && ev_ready;
        wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop  ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        valid_d = (count_d != '0);
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // Event storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= drain_id;
        end
    end

    // Stale storage is masked so an empty FIFO always presents id 0.
    assign ev_valid   = valid_q;
    assign ev_id      = valid_q ? id_mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;

`ifdef SENSOR_EVENT_HUB_TIMESTAMP_EN
    // ------------------------------------------------------------------
    // Timestamps: captured when a channel becomes pending, carried in FIFO
    // ------------------------------------------------------------------
    logic [TS_W-1:0]              ts_q, ts_d;
    logic [NUM_CH-1:0][TS_W-1:0]  ts_cap_vec;
    logic [TS_W-1:0]              ts_mem_q [FIFO_DEPTH];

    // Free-running counter, wraps naturally at 2^TS_W
    always_comb begin
        ts_d = ts_q + TS_W'(1);
    end

    // Timestamp counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ts
            logic [TS_W-1:0] cap_q, cap_d;

            // Capture only for a fresh event; coalesced rises keep the first time
            always_comb begin
                cap_d = cap_q;
                if (rise[gi] && !coalesce[gi]) begin
                    cap_d = ts_q;
                end
            end

            // Per-channel captured timestamp
            always_ff @(posedge clk) begin
                if (rst) begin
                    cap_q <= '0;
                end else begin
                    cap_q <= cap_d;
                end
            end

            assign ts_cap_vec[gi] = cap_q;
        end
    endgenerate

    // Timestamp storage written alongside the id
    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem_q[wr_ptr_q] <= ts_cap_vec[drain_id];
        end
    end

    assign ev_ts = valid_q ? ts_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_sensor_event_hub.sv
// Testbench for sensor_event_hub (NUM_CH=9, HOLD_CYCLES=4, FIFO_DEPTH=4).
// A behavioural model running on the rising edge predicts accepted levels,
// pending events, FIFO occupancy and overflow; drained event ids go into a
// scoreboard queue that a negedge monitor pops on every handshake.
module tb_sensor_event_hub;

    localparam int NUM_CH = 9;
    localparam int HOLD   = 4;
    localparam int DEPTH  = 4;
    localparam int ID_W   = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr_ovf = 1'b0;
    logic              ev_ready = 1'b0;
    logic [NUM_CH-1:0] ev_in = '0;
    logic              ev_valid;
    logic [ID_W-1:0]   ev_id;
    logic [NUM_CH-1:0] ev_state;
    logic              overflow;
    logic [$clog2(DEPTH):0] fifo_count;
`ifdef SENSOR_EVENT_HUB_TIMESTAMP_EN
    logic [15:0]       ev_ts;
`endif

    sensor_event_hub #(
        .NUM_CH(NUM_CH),
        .HOLD_CYCLES(HOLD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ev_in(ev_in),
        .clr_ovf(clr_ovf),
        .ev_ready(ev_ready),
        .ev_valid(ev_valid),
        .ev_id(ev_id),
        .ev_state(ev_state),
        .overflow(overflow),
`ifdef SENSOR_EVENT_HUB_TIMESTAMP_EN
        .ev_ts(ev_ts),
`endif
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pop_cnt = 0;

    int sb_q[$];
    int model_q[$];

    // model state
    logic [NUM_CH-1:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_rise = '0;
    logic [NUM_CH-1:0] m_pend = '0;
    logic              m_ovf = 1'b0;
    int                m_run [NUM_CH];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Reference model: advanced once per rising edge from the rules
    initial begin
        logic [NUM_CH-1:0] nst;
        logic [NUM_CH-1:0] drain;
        int lo;
        bit full;
        for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = '0; m_s2 = '0; m_st = '0; m_rise = '0;
                m_pend = '0; m_ovf = 1'b0;
                for (int i = 0; i < NUM_CH; i++) m_run[i] = 0;
                model_q.delete();
                sb_q.delete();
            end else begin
                full = (model_q.size() >= DEPTH);
                lo = -1;
                for (int i = 0; i < NUM_CH; i++)
                    if (m_pend[i] && lo < 0) lo = i;
                drain = '0;
                if (full) lo = -1;
                if (lo >= 0) drain[lo] = 1'b1;
                if (model_q.size() > 0 && ev_ready) void'(model_q.pop_front());
                if (lo >= 0) begin
                    model_q.push_back(lo);
                    sb_q.push_back(lo);
                end
                m_ovf  = (|(m_rise & m_pend & ~drain)) | (m_ovf & ~clr_ovf);
                m_pend = (m_pend & ~drain) | m_rise;
                nst = m_st;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_s2[i] != m_st[i]) begin
                        if (m_run[i] == HOLD - 1) begin
                            nst[i] = m_s2[i];
                            m_run[i] = 0;
                        end else begin
                            m_run[i] = m_run[i] + 1;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_rise = nst & ~m_st;
                m_st   = nst;
                m_s2   = m_s1;
                m_s1   = ev_in;
            end
        end
    end

    // Monitor: compare status every cycle and pop the scoreboard on handshakes
    initial begin
        int exp_id;
        forever begin
            @(negedge clk);
            chk("valid", int'(ev_valid), int'(model_q.size() != 0));
            chk("count", int'(fifo_count), model_q.size());
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("ev_state", int'(ev_state), int'(m_st));
            if (ev_valid && ev_ready && !rst) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", sb_q.size(), 1);
                end else begin
                    exp_id = sb_q.pop_front();
                    chk("ev_id", int'(ev_id), exp_id);
                    pop_cnt++;
                    $display("event id=%0d expected=%0d count=%0d t=%0t", ev_id, exp_id, fifo_count, $time);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 300000", $time);
        $fatal(1);
    end

    initial begin
        int pc0;
        int maxc;
        int mode;

        // Reset
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_count", int'(fifo_count), 0);
        chk("rst_state", int'(ev_state), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_id", int'(ev_id), 0);

        // Debounce: 3-cycle glitch is rejected
        step(1);
        ev_in[2] = 1'b1;
        step(3);
        ev_in[2] = 1'b0;
        step(20);
        @(negedge clk);
        chk("glitch_state", int'(ev_state[2]), 0);
        chk("glitch_count", int'(fifo_count), 0);

        // Debounce latency: state after edge 6, valid after edge 8
        @(posedge clk);
        #2;
        ev_ready = 1'b0;
        ev_in[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("lat_state_e%0d", e), int'(ev_state[2]), int'(e >= 6));
            chk($sformatf("lat_valid_e%0d", e), int'(ev_valid), int'(e >= 8));
        end
        chk("lat_id", int'(ev_id), 2);
        #1;
        ev_ready = 1'b1;
        step(4);

        // Arbitration: 1 and 5 together drain as 1 then 5
        pc0 = pop_cnt;
        ev_in[5] = 1'b1;
        ev_in[1] = 1'b1;
        maxc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
        end
        chk("arb_maxcount", maxc, 1);
        chk("arb_pops", pop_cnt - pc0, 2);

        // Backpressure: six events into a four-deep FIFO
        step(1);
        ev_in = '0;
        step(15);
        ev_ready = 1'b0;
        ev_in = 9'h03F;
        step(25);
        @(negedge clk);
        chk("bp_count", int'(fifo_count), 4);
        chk("bp_id", int'(ev_id), 0);
        chk("bp_valid", int'(ev_valid), 1);
        pc0 = pop_cnt;
        step(1);
        ev_ready = 1'b1;
        step(15);
        @(negedge clk);
        chk("bp_pops", pop_cnt - pc0, 6);
        chk("bp_ovf", int'(overflow), 0);

        // Overflow: full FIFO, channel 3 pending, re-toggled
        step(1);
        ev_in = '0;
        step(15);
        ev_ready = 1'b0;
        ev_in = 9'h017;
        step(20);
        ev_in[3] = 1'b1;
        step(12);
        ev_in[3] = 1'b0;
        step(12);
        ev_in[3] = 1'b1;
        step(12);
        @(negedge clk);
        chk("ovf_set", int'(overflow), 1);
        step(1);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_clr", int'(overflow), 0);
        step(1);
        ev_in[3] = 1'b0;
        step(12);
        ev_in[3] = 1'b1;
        step(6);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_set_wins", int'(overflow), 1);
        step(1);
        ev_in = '0;
        ev_ready = 1'b1;
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        step(20);

        // Reset mid-stream discards queued events; held inputs re-fire
        ev_ready = 1'b0;
        ev_in = 9'h007;
        step(15);
        @(negedge clk);
        chk("rs_pre_count", int'(fifo_count), 3);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_valid", int'(ev_valid), 0);
        chk("rs_count", int'(fifo_count), 0);
        chk("rs_state", int'(ev_state), 0);
        chk("rs_id", int'(ev_id), 0);
        pc0 = pop_cnt;
        step(1);
        ev_ready = 1'b1;
        step(15);
        @(negedge clk);
        chk("rs_fresh_pops", pop_cnt - pc0, 3);

        // Randomised traffic
        step(1);
        ev_in = '0;
        mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            for (int b = 0; b < NUM_CH; b++)
                if ($urandom_range(0, 23) == 0) ev_in[b] = ~ev_in[b];
            case (mode)
                0: ev_ready = 1'b1;
                1: ev_ready = 1'($urandom_range(0, 1));
                default: ev_ready = ($urandom_range(0, 7) == 0);
            endcase
            clr_ovf = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 999) == 0);
            step(1);
        end

        // Drain and finish
        rst = 1'b0;
        clr_ovf = 1'b0;
        ev_in = '0;
        ev_ready = 1'b1;
        step(30);
        @(negedge clk);
        chk("end_sb_empty", sb_q.size(), 0);
        chk("end_count", int'(fifo_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
